// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus responder.
package mem_bus_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} busStateT;

   localparam logic [15:0] MMIO_ADDR = 16'hFFFF;
   localparam int          LAT_MIN   = 1;
   localparam int          LAT_MAX   = 7;

endpackage

// File: rtl/bus_ram.sv
// Single-port word RAM: synchronous write, registered read output.
module bus_ram #(
   parameter int WIDTH    = 16,
   parameter int ADDRBITS = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we,
   input  logic                re,
   input  logic [ADDRBITS-1:0] addr,
   input  logic [WIDTH-1:0]    wdata,
   output logic [WIDTH-1:0]    rdata
);

   logic [WIDTH-1:0] mem [2**ADDRBITS];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   // Only the output register is cleared; array contents survive reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Valid/ready memory responder with fixed read latency over bus_ram.
// Optional LED output register enabled by MEM_BUS_MMIO_LEDS_EN.
module mem_bus_responder
   import mem_bus_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int ADDRBITS = 10,
   parameter int LATENCY  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err
`ifdef MEM_BUS_MMIO_LEDS_EN
   ,output logic [7:0]      leds
`endif
);

   localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN :
                        (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
   localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

   busStateT            state, nextState;
   logic [2:0]          waitCnt;
   logic [ADDRBITS-1:0] addrQ, ramAddr;
   logic                errQ, okQ, mmioQ, useRam;
   logic [WIDTH-1:0]    ramQ, altData;
   logic                accept, inRange, isMmio, curOk, curMmio, rdLoad, ramWe, ramRe;

   assign accept  = req_valid & (state == IDLE);
   assign inRange = (req_addr[WIDTH-1:ADDRBITS] == '0);
`ifdef MEM_BUS_MMIO_LEDS_EN
   assign isMmio  = (req_addr == WIDTH'(MMIO_ADDR));
`else
   assign isMmio  = 1'b0;
`endif

   // In IDLE the decode comes straight from the bus (accept edge); later from the latches.
   assign curOk   = (state == IDLE) ? inRange : okQ;
   assign curMmio = (state == IDLE) ? isMmio  : mmioQ;
   assign ramAddr = (state == IDLE) ? req_addr[ADDRBITS-1:0] : addrQ;
   assign rdLoad  = (accept & ~req_we & (LAT == 1)) | ((state == WAIT) & (waitCnt == 3'd1));
   assign ramWe   = accept & req_we & inRange & ~isMmio;
   assign ramRe   = rdLoad & curOk & ~curMmio;

   bus_ram #(.WIDTH(WIDTH), .ADDRBITS(ADDRBITS)) uRam (
      .clk   (clk),
      .reset (reset),
      .we    (ramWe),
      .re    (ramRe),
      .addr  (ramAddr),
      .wdata (req_wdata),
      .rdata (ramQ)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: if (req_valid) nextState = (req_we || LAT == 1) ? RESP : WAIT;
         WAIT: if (waitCnt == 3'd1) nextState = RESP;
         RESP: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      resp_err   = (state == RESP) & errQ;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         waitCnt <= '0;
         addrQ   <= '0;
         errQ    <= 1'b0;
         okQ     <= 1'b0;
         mmioQ   <= 1'b0;
         useRam  <= 1'b0;
         altData <= '0;
      end else begin
         if (accept) begin
            addrQ <= req_addr[ADDRBITS-1:0];
            errQ  <= ~isMmio & ~inRange;
            okQ   <= inRange;
            mmioQ <= isMmio;
         end
         if (accept && !req_we && LAT > 1) waitCnt <= CNT_INIT;
         else if (state == WAIT)           waitCnt <= waitCnt - 3'd1;
         // Read-data source is chosen on the edge entering RESP and then held.
         if (rdLoad) begin
            useRam <= curOk & ~curMmio;
`ifdef MEM_BUS_MMIO_LEDS_EN
            altData <= curMmio ? {{(WIDTH-8){1'b0}}, leds} : '0;
`else
            altData <= '0;
`endif
         end
      end
   end

   assign resp_rdata = useRam ? ramQ : altData;

`ifdef MEM_BUS_MMIO_LEDS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                         leds <= 8'h00;
      else if (accept && req_we && isMmio) leds <= req_wdata[7:0];
   end
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: main instance at LATENCY 2 plus 1/3/7 sweep copies.
module tb_mem_bus_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [15:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err;
   logic [15:0] resp_rdata;
   logic [2:0]  swReady, swValid, swErr;
   logic [15:0] swRdata [3];
`ifdef MEM_BUS_MMIO_LEDS_EN
   logic [7:0]  leds;
   logic [7:0]  swLeds [3];
`endif

   int vectors = 0, miscompares = 0;
   logic [15:0] lastRd = 16'h0000;

   typedef struct {logic we; logic err; logic [15:0] data; int lat;} expT;
   expT sbq[$];

   always #5 clk = ~clk;

   mem_bus_responder #(.WIDTH(16), .ADDRBITS(10), .LATENCY(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
`ifdef MEM_BUS_MMIO_LEDS_EN
      , .leds(leds)
`endif
   );

   mem_bus_responder #(.WIDTH(16), .ADDRBITS(10), .LATENCY(1)) dutL1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(swReady[0]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(swValid[0]), .resp_rdata(swRdata[0]), .resp_err(swErr[0])
`ifdef MEM_BUS_MMIO_LEDS_EN
      , .leds(swLeds[0])
`endif
   );

   mem_bus_responder #(.WIDTH(16), .ADDRBITS(10), .LATENCY(3)) dutL3 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(swReady[1]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(swValid[1]), .resp_rdata(swRdata[1]), .resp_err(swErr[1])
`ifdef MEM_BUS_MMIO_LEDS_EN
      , .leds(swLeds[1])
`endif
   );

   mem_bus_responder #(.WIDTH(16), .ADDRBITS(10), .LATENCY(7)) dutL7 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(swReady[2]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(swValid[2]), .resp_rdata(swRdata[2]), .resp_err(swErr[2])
`ifdef MEM_BUS_MMIO_LEDS_EN
      , .leds(swLeds[2])
`endif
   );

   // Drive one request on the main instance, then check its response against the scoreboard.
   task automatic sendReq(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic expErr, input logic [15:0] expData, input int expLat);
      expT e;
      int  n = 0;
      int  lat = 0;
      logic readyBad = 1'b0;
      logic got = 1'b0;
      sbq.push_back('{we, expErr, expData, expLat});
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      for (int i = 1; i <= 15 && !got; i++) begin
         @(negedge clk);
         if (i == 1) begin
            req_valid = 1'b0; req_addr = 16'h3C3C; req_wdata = 16'h0;
         end
         if (req_ready) readyBad = 1'b1;
         if (resp_valid) begin
            got = 1'b1;
            lat = i;
         end
      end
      e = sbq.pop_front();
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL resp_timeout addr=%h: got no resp_valid, want one at %0d", addr, e.lat);
      end else begin
         vectors += 3;
         if (lat != e.lat) begin
            miscompares++;
            $display("FAIL latency addr=%h: got %0d, want %0d", addr, lat, e.lat);
         end
         if (resp_err !== e.err) begin
            miscompares++;
            $display("FAIL resp_err addr=%h: got %b, want %b", addr, resp_err, e.err);
         end
         if (resp_rdata !== (e.we ? lastRd : e.data)) begin
            miscompares++;
            $display("FAIL rdata addr=%h we=%b: got %h, want %h", addr, e.we, resp_rdata,
                     e.we ? lastRd : e.data);
         end
         if (!e.we) lastRd = e.data;
      end
      if (readyBad) begin
         miscompares++;
         $display("FAIL ready_busy addr=%h: got req_ready=1 while busy, want 0", addr);
      end
   endtask

   task automatic test_reset();
      int spurious = 0;
      @(negedge clk);
      vectors += 3;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b, want 1", req_ready); end
      if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, want 0", resp_valid); end
      if (resp_rdata !== 16'h0) begin miscompares++; $display("FAIL rst_rdata: got %h, want 0000", resp_rdata); end
      reset = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0005;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (resp_valid) spurious++;
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (resp_valid) spurious++;
      end
      vectors += 3;
      if (spurious != 0) begin miscompares++; $display("FAIL rst_abandon: got %0d resp pulses, want 0", spurious); end
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_after: got %b, want 1", req_ready); end
      if (resp_rdata !== 16'h0) begin miscompares++; $display("FAIL rst_rdata_after: got %h, want 0000", resp_rdata); end
   endtask

   task automatic test_write_read();
      sendReq(1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0, 1);
      sendReq(1'b0, 16'h0005, 16'h0, 1'b0, 16'hBEEF, 2);
   endtask

   task automatic test_latency_sweep();
      int  lat [3];
      int  expLat [3] = '{1, 3, 7};
      logic readyBad = 1'b0;
      for (int i = 0; i < 12; i++) @(negedge clk);
      lat = '{0, 0, 0};
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0005;
      @(posedge clk);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (n == 1) req_valid = 1'b0;
         for (int k = 0; k < 3; k++) begin
            if (lat[k] == 0) begin
               if (swValid[k]) lat[k] = n;
               else if (swReady[k]) readyBad = 1'b1;
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (lat[k] != expLat[k]) begin
            miscompares++;
            $display("FAIL sweep_latency L%0d: got %0d, want %0d", expLat[k], lat[k], expLat[k]);
         end
         vectors++;
         if (swRdata[k] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL sweep_rdata L%0d: got %h, want beef", expLat[k], swRdata[k]);
         end
      end
      vectors++;
      if (readyBad) begin miscompares++; $display("FAIL sweep_ready: got req_ready=1 while busy, want 0"); end
   endtask

   task automatic test_out_of_range();
      sendReq(1'b1, 16'h0000, 16'h5A5A, 1'b0, 16'h0, 1);
      sendReq(1'b1, 16'h0400, 16'h1234, 1'b1, 16'h0, 1);
      sendReq(1'b0, 16'h0400, 16'h0, 1'b1, 16'h0000, 2);
      sendReq(1'b0, 16'h0000, 16'h0, 1'b0, 16'h5A5A, 2);
`ifndef MEM_BUS_MMIO_LEDS_EN
      sendReq(1'b0, 16'hFFFF, 16'h0, 1'b1, 16'h0000, 2);
`endif
   endtask

   task automatic test_held_valid();
      int accepts = 0, resps = 0;
      for (int i = 0; i < 10; i++) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0005;
         if (req_ready) accepts++;
         if (resp_valid) resps++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      vectors += 2;
      if (accepts != 2) begin miscompares++; $display("FAIL held_accepts: got %0d, want 2", accepts); end
      if (resps != 2) begin miscompares++; $display("FAIL held_resps: got %0d, want 2", resps); end
      lastRd = 16'hBEEF;
   endtask

   task automatic test_back_to_back();
      sendReq(1'b1, 16'h0007, 16'h1357, 1'b0, 16'h0, 1);
      sendReq(1'b0, 16'h0007, 16'h0, 1'b0, 16'h1357, 2);
      sendReq(1'b1, 16'h0007, 16'h2468, 1'b0, 16'h0, 1);
      sendReq(1'b0, 16'h0007, 16'h0, 1'b0, 16'h2468, 2);
   endtask

`ifdef MEM_BUS_MMIO_LEDS_EN
   task automatic test_mmio();
      sendReq(1'b1, 16'hFFFF, 16'h00A5, 1'b0, 16'h0, 1);
      vectors++;
      if (leds !== 8'hA5) begin miscompares++; $display("FAIL mmio_leds: got %h, want a5", leds); end
      sendReq(1'b0, 16'hFFFF, 16'h0, 1'b0, 16'h00A5, 2);
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_latency_sweep();
      test_held_valid();
      test_out_of_range();
      test_back_to_back();
`ifdef MEM_BUS_MMIO_LEDS_EN
      test_mmio();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the 16-bit datapath's memory port. It answers the datapath's read and write requests from an on-chip single-port word RAM.
- Adds a valid/ready request handshake and a fixed-latency response, so the control FSM can stall on memory.
- Sits between the datapath (address, store data, load data) and the RAM. Also decodes one optional memory-mapped output register.

Parameters:
- WIDTH, 16, data and address word width in bits.
- ADDRBITS, 10, RAM index bits; depth is 2**ADDRBITS words.
- LATENCY, 2, cycles from read-accept edge to resp_valid; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  requester presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read; sampled on accept.
- req_addr  input  WIDTH  word address; sampled on accept.
- req_wdata  input  WIDTH  store data; sampled on accept.
- resp_valid  output  1  single-cycle pulse: read data or write acknowledge.
- resp_rdata  output  WIDTH  read data; meaningful when resp_valid is high and the request was a read.
- resp_err  output  1  asserted together with resp_valid when the request address was out of range.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, wait counter = 0.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - RAM contents are not reset.
- FSM states IDLE, WAIT, RESP:
  - req_ready = (state == IDLE), driven from state only; no combinational path from req_valid.
  - Accept happens on a rising edge with req_valid & req_ready. Address, we and wdata are latched at that edge.
- Write:
  - The RAM is written at the accept edge.
  - IDLE -> RESP; resp_valid is high in the next cycle, resp_err per the range check.
  - resp_rdata is unchanged.
- Read:
  - If LATENCY == 1: IDLE -> RESP.
  - Otherwise: IDLE -> WAIT with counter = LATENCY-1. The counter decrements each cycle, and WAIT -> RESP when it reaches 1.
  - resp_valid is high exactly LATENCY cycles after the accept edge.
  - resp_rdata is loaded on the edge that enters RESP and holds until the next read response.
- RESP always goes to IDLE after one cycle. resp_valid is therefore a one-cycle pulse with no response backpressure; the requester must capture it.
- Throughput:
  - reads: one per LATENCY+1 cycles.
  - writes: one per 2 cycles.
  - A new request may be accepted in the cycle after resp_valid.
- Range check: the address is in range iff req_addr[WIDTH-1:ADDRBITS] == 0. Out of range:
  - a write is dropped;
  - a read returns 0;
  - resp_err = 1 with resp_valid.
  - Index is req_addr[ADDRBITS-1:0].
- Corner cases:
  - req_valid held high while not ready: ignored; no queueing.
  - req_addr changing mid-operation: has no effect.
  - Reset mid-operation: the transaction is abandoned and no response is issued. A write already committed at accept stays in RAM.
  - Read-after-write to the same address on back-to-back transactions returns the new data.

Optional Feature:
- Macro MEM_BUS_MMIO_LEDS_EN.
- Defined:
  - adds output port leds [7:0], reset value 8'h00;
  - address MMIO_ADDR (all ones, 16'hFFFF) is decoded before the range check;
  - a write sets leds = req_wdata[7:0], with resp_err = 0;
  - a read returns {8'h00, leds}, with resp_err = 0.
- Undefined: no leds port; 16'hFFFF is an ordinary out-of-range address.

Decomposition:
- Package mem_bus_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - MMIO_ADDR constant;
  - LATENCY legal-range constants.
- One sub-module, bus_ram: single-port RAM with synchronous write and synchronous registered read, parameterised by WIDTH and ADDRBITS. The responder owns all control logic.

Test Plan:
- Reset: drive reset low mid-read (LATENCY=2) -> resp_valid stays 0, req_ready = 1 and resp_rdata = 16'h0000 after release.
- Write then read: write addr 16'h0005 data 16'hBEEF -> ack 1 cycle later, resp_err = 0. Read 16'h0005 -> resp_valid exactly 2 cycles after accept, rdata 16'hBEEF.
- Latency sweep: LATENCY = 1, 3, 7 -> read resp_valid at exactly 1, 3, 7 cycles after accept; req_ready low throughout.
- Out of range: write 16'h0400 data 16'h1234, then read 16'h0400 -> both responses have resp_err = 1, read data 16'h0000. RAM index 0 is unchanged.
- Held valid: req_valid held high for 6 cycles with a constant read request, LATENCY=2 -> exactly two accepts (cycles 0 and 3) and two resp_valid pulses.
- MMIO (macro defined): write 16'hFFFF data 16'h00A5 -> leds = 8'hA5, resp_err = 0. Read 16'hFFFF -> rdata 16'h00A5.
